// File: rtl/sr_latch_ctrl.sv
// Purpose: arbitrates requesters A/B onto one NOR SR latch, pulses S or R, reads Q back through a 2-flop synchronizer.
// Latency: grant in cycle 0, S/R high in cycles 1..PULSE_W, ack in cycle PULSE_W+SETTLE_W+1, IDLE the cycle after.
// Backpressure: a requester holds req/op until its ack; requests arriving while busy wait in IDLE arbitration.
//
// Optional feature macro: SR_SKIP_REDUNDANT_EN (when defined, an op that matches latch_state acks in cycle 1 without pulsing).
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   req_a/op_a/ack_a    - requester A: request, op (1 = set, 0 = reset), one-cycle completion strobe
//   req_b/op_b/ack_b    - requester B: same as A
//   err                 - valid with ack_a/ack_b: read-back Q disagrees with the requested op
//   busy                - high whenever the FSM is not in IDLE
//   S, R                - registered latch drives, never high together
//   Q                   - latch output, asynchronous to clk
//   latch_state         - Q after the 2-flop synchronizer
module sr_latch_ctrl #(
    parameter int PULSE_W  = 2,
    parameter int SETTLE_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic op_a,
    output logic ack_a,
    input  logic req_b,
    input  logic op_b,
    output logic ack_b,
    output logic err,
    output logic busy,
    output logic S,
    output logic R,
    input  logic Q,
    output logic latch_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       op_q;      // captured op of the granted requester
    logic       id_q;      // granted requester: 1 = B, 0 = A
    logic       last_b;    // 1 = B was granted last, so A wins the next tie
    logic       sync1;

    logic       any_req;
    logic       grant_b;
    logic       next_op;
    logic       skip;

    // Round-robin: a lone request wins outright; on a tie the side not granted last wins.
    always_comb begin
        any_req = req_a | req_b;
        grant_b = req_b & (~req_a | ~last_b);
        next_op = grant_b ? op_b : op_a;
    end

`ifdef SR_SKIP_REDUNDANT_EN
    // Latch already holds the requested value: no pulse needed.
    assign skip = (next_op == latch_state);
`else
    assign skip = 1'b0;
`endif

    // Two-flop synchronizer on the asynchronous latch output; runs in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            latch_state <= 1'b0;
        end else begin
            sync1       <= Q;
            latch_state <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            op_q   <= 1'b0;
            id_q   <= 1'b0;
            last_b <= 1'b1;
            S      <= 1'b0;
            R      <= 1'b0;
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            // Strobes are single-cycle; only the transition into DONE raises them.
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_q   <= next_op;
                        id_q   <= grant_b;
                        last_b <= grant_b;
                        busy   <= 1'b1;
                        if (skip) begin
                            state <= DONE;
                            ack_a <= ~grant_b;
                            ack_b <= grant_b;
                        end else begin
                            state <= PULSE;
                            cnt   <= 8'(PULSE_W - 1);
                            S     <= next_op;
                            R     <= ~next_op;
                        end
                    end
                end
                PULSE: begin
                    if (cnt == 8'd0) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        cnt   <= 8'(SETTLE_W - 1);
                        state <= SETTLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SETTLE: begin
                    if (cnt == 8'd0) begin
                        // Read-back is the synchronized Q seen in the last settle
                        // cycle; SETTLE_W >= 2 lets the pulse reach latch_state first.
                        state <= DONE;
                        ack_a <= ~id_q;
                        ack_b <= id_q;
                        err   <= (latch_state != op_q);
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    S     <= 1'b0;
                    R     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Purpose: self-checking bench for sr_latch_ctrl driving a NOR-gate latch model with an optional stuck-at override.
// Latency: expectations derived from PULSE_W/SETTLE_W and the arbitration/skip rules.
// Backpressure: requesters hold req/op until ack, then drop; a held loser is served next.
module tb_sr_latch_ctrl;

    localparam int PW = 2;
    localparam int SW = 3;

    logic clk;
    logic rst_n;
    logic req_a, op_a, ack_a;
    logic req_b, op_b, ack_b;
    logic err, busy, S, R, Q, latch_state;

    // Latch model: cross-coupled NOR gates with 1 ns delay, plus a one-time clear
    // and a stuck-at override used for read-back failures.
    logic init_clr;
    logic q_nor, qn_nor;
    logic st_en, st_val;
    assign #1 q_nor  = ~(R | init_clr | qn_nor);
    assign #1 qn_nor = ~(S | q_nor);
    assign Q = st_en ? st_val : q_nor;

    sr_latch_ctrl #(.PULSE_W(PW), .SETTLE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .op_a(op_a), .ack_a(ack_a),
        .req_b(req_b), .op_b(op_b), .ack_b(ack_b),
        .err(err), .busy(busy), .S(S), .R(R), .Q(Q),
        .latch_state(latch_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit nor_m;    // value the NOR latch itself holds
    bit last_b;   // requester granted last (1 = B)

    typedef struct {
        bit ra, oa, rb, ob;
        bit s_en, s_val;
        bit gb;
        bit e_err;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit skip_for(input bit op);
        bit s;
        s = 1'b0;
`ifdef SR_SKIP_REDUNDANT_EN
        s = (op == ((st_en === 1'b1) ? st_val : nor_m));
`endif
        return s;
    endfunction

    function automatic bit err_for(input bit op);
        bit vis;
        vis = (st_en === 1'b1) ? st_val : op;
        return skip_for(op) ? 1'b0 : (vis != op);
    endfunction

    // Entered in the grant cycle (cycle 0); leaves in the IDLE cycle after the ack.
    task automatic serve(input bit gb, input bit op, input bit exp_err, input bit wiggle);
        bit skip;
        int lat;
        bit pulse;
        skip = skip_for(op);
        lat  = skip ? 1 : PW + SW + 1;
        chk("busy_c0", busy, 1'b0);
        last_b = gb;
        for (int c = 1; c <= lat; c++) begin
            tick();
            if (wiggle && c == 1) begin
                if (gb) op_b = ~op_b; else op_a = ~op_a;
            end
            pulse = !skip && (c <= PW);
            chk("S", S, pulse ? op : 1'b0);
            chk("R", R, pulse ? ~op : 1'b0);
            chk("s_and_r", S & R, 1'b0);
            chk("busy", busy, 1'b1);
            if (c == lat) begin
                chk("ack_a", ack_a, ~gb);
                chk("ack_b", ack_b, gb);
                chk("err", err, exp_err);
            end else begin
                chk("ack_a_early", ack_a, 1'b0);
                chk("ack_b_early", ack_b, 1'b0);
                chk("err_noack", err, 1'b0);
            end
        end
        if (!skip) nor_m = op;
        if (gb) req_b = 1'b0; else req_a = 1'b0;
        tick();
        chk("busy_idle", busy, 1'b0);
        chk("ack_a_off", ack_a, 1'b0);
        chk("ack_b_off", ack_b, 1'b0);
        chk("err_off", err, 1'b0);
        chk("latch_state", latch_state, (st_en === 1'b1) ? st_val : nor_m);
    endtask

    initial begin
        bit gb, op, ra, rb;

        //      ra oa rb ob en val gb err
        tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0};  // single set from A
        tbl[1] = '{0, 0, 1, 0, 0, 0, 1, 0};  // B reset alone, pointer -> B
        tbl[2] = '{1, 0, 1, 1, 0, 0, 0, 0};  // contention: A first (R pulse)
        tbl[3] = '{1, 0, 0, 0, 0, 0, 1, 0};  // A re-raises with B held: B wins (S pulse)
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0};  // held A served
        tbl[5] = '{0, 0, 1, 1, 1, 0, 1, 1};  // Q stuck 0, set from B -> err
        tbl[6] = '{1, 1, 0, 0, 0, 0, 0, 0};  // latch already 1, set from A
        tbl[7] = '{1, 0, 0, 0, 1, 1, 0, 1};  // Q stuck 1, reset from A -> err
        tbl[8] = '{0, 0, 1, 0, 0, 0, 1, 0};  // latch already 0, reset from B

        rst_n    = 1'b0;
        init_clr = 1'b1;
        st_en    = 1'b0;
        st_val   = 1'b0;
        req_a    = 1'b1; op_a = 1'b0;
        req_b    = 1'b1; op_b = 1'b0;
        nor_m    = 1'b0;
        last_b   = 1'b1;
        #20 init_clr = 1'b0;

        // Reset held with both requests high
        repeat (3) tick();
        chk("rst_S", S, 1'b0);
        chk("rst_R", R, 1'b0);
        chk("rst_ack_a", ack_a, 1'b0);
        chk("rst_ack_b", ack_b, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_latch_state", latch_state, 1'b0);
        rst_n = 1'b1;
        serve(1'b0, 1'b0, 1'b0, 1'b0);   // A first after reset
        serve(1'b1, 1'b0, 1'b0, 1'b0);   // then held B

        // Directed table
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].s_en != st_en || tbl[i].s_val != st_val) begin
                st_en  = tbl[i].s_en;
                st_val = tbl[i].s_val;
                repeat (3) tick();
            end
            if (tbl[i].ra) begin req_a = 1'b1; op_a = tbl[i].oa; end
            if (tbl[i].rb) begin req_b = 1'b1; op_b = tbl[i].ob; end
            serve(tbl[i].gb, tbl[i].gb ? op_b : op_a, tbl[i].e_err, 1'b0);
        end

        // Reset in the first pulse cycle of a set
        req_a = 1'b1; op_a = 1'b1;
        tick();
        chk("mid_S_before", S, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_S_async", S, 1'b0);
        chk("mid_R_async", R, 1'b0);
        chk("mid_busy_async", busy, 1'b0);
        req_a = 1'b0;
        tick();
        rst_n  = 1'b1;
        nor_m  = 1'b1;   // the partial S pulse outlasted the gate delays
        last_b = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_ack_a", ack_a, 1'b0);
            chk("post_rst_S", S, 1'b0);
        end

        // Randomized traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            st_en  = ($urandom_range(0, 3) == 0);
            st_val = 1'($urandom_range(0, 1));
            repeat (3) tick();
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            req_a = ra; op_a = 1'($urandom_range(0, 1));
            req_b = rb; op_b = 1'($urandom_range(0, 1));
            while (req_a || req_b) begin
                gb = req_b && (!req_a || !last_b);
                op = gb ? op_b : op_a;
                serve(gb, op, err_for(op), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
